// File: rtl/vram_writer_if.sv
// Display-port / VRAM-write-port bundle between the character source, the writer and the renderer.
// The master side drives characters and clear requests; the slave side is the writer itself.
interface vram_writer_if;
  logic [6:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic        clr_screen;
  logic [10:0] vram_waddr;
  logic [5:0]  vram_din;
  logic        vram_we;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [4:0]  top_row;

  modport master (
    output char_in, char_valid, clr_screen,
    input  char_ready, vram_waddr, vram_din, vram_we, cursor_col, cursor_row, top_row
  );

  modport slave (
    input  char_in, char_valid, clr_screen,
    output char_ready, vram_waddr, vram_din, vram_we, cursor_col, cursor_row, top_row
  );
endinterface

// File: rtl/vram_writer.sv
// Apple-1 terminal writer: turns ASCII into glyph writes into video RAM, handling cursor,
// CR/auto-newline, top-row hardware scroll, bottom-line clearing and full-screen clearing.
module vram_writer #(
  parameter int         COLS  = 40,
  parameter int         ROWS  = 24,
  parameter logic [5:0] BLANK = 6'h20
) (
  input  logic         clk,
  input  logic         rst_n,
  vram_writer_if.slave bus
);

  localparam logic [5:0]  COLS_M1  = 6'(COLS - 1);
  localparam logic [4:0]  ROWS_M1  = 5'(ROWS - 1);
  localparam logic [5:0]  ROWS_W   = 6'(ROWS);
  localparam logic [11:0] CNT_COLS = 12'(COLS);
  localparam logic [11:0] CNT_ALL  = 12'd2048;
  localparam logic [6:0]  CR       = 7'h0D;

  typedef enum logic [2:0] {
    CLR_ALL,
    IDLE,
    WRITE,
    NEWLINE,
    CLR_LINE
  } state_t;

  state_t      state_reg, state_next;
  logic [11:0] cnt_reg, cnt_next;
  logic [5:0]  col_reg, col_next;
  logic [4:0]  row_reg, row_next;
  logic [4:0]  top_reg, top_next;
  logic        we_reg, we_next;
  logic [10:0] addr_reg, addr_next;
  logic [5:0]  din_reg, din_next;
  logic        ready_reg, ready_next;

  logic        accept;
  logic        printable;
  logic [6:0]  folded;
  logic [5:0]  glyph;
  logic [4:0]  phys_row;

  // (top + row) mod ROWS; both operands are below ROWS so one conditional subtract suffices.
  function automatic logic [4:0] phys_of(input logic [4:0] top, input logic [4:0] row);
    logic [5:0] sum;
    sum = {1'b0, top} + {1'b0, row};
    if (sum >= ROWS_W) begin
      sum = sum - ROWS_W;
    end
    return sum[4:0];
  endfunction

  assign accept    = bus.char_valid && ready_reg;
  assign printable = |bus.char_in[6:5];
  assign folded    = bus.char_in - 7'h20;
  assign glyph     = (bus.char_in[6:5] == 2'b11) ? folded[5:0] : bus.char_in[5:0];
  assign phys_row  = phys_of(top_reg, row_reg);

  // Outputs are registered from the next-state decision so they line up with the state they belong to.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    top_next   = top_reg;
    we_next    = 1'b0;
    addr_next  = addr_reg;
    din_next   = din_reg;
    ready_next = 1'b0;

    if (bus.clr_screen) begin
      state_next = CLR_ALL;
      cnt_next   = 12'd0;
    end else begin
      case (state_reg)
        CLR_ALL: begin
          if (cnt_reg == CNT_ALL) begin
            state_next = IDLE;
            col_next   = 6'd0;
            row_next   = 5'd0;
            top_next   = 5'd0;
            ready_next = 1'b1;
          end else begin
            we_next   = 1'b1;
            addr_next = cnt_reg[10:0];
            din_next  = BLANK;
            cnt_next  = cnt_reg + 12'd1;
          end
        end

        IDLE: begin
          ready_next = 1'b1;
          if (accept) begin
            if (printable) begin
              state_next = WRITE;
              ready_next = 1'b0;
              we_next    = 1'b1;
              addr_next  = {phys_row, col_reg};
              din_next   = glyph;
            end else if (bus.char_in == CR) begin
              state_next = NEWLINE;
              ready_next = 1'b0;
            end
          end
        end

        WRITE: begin
          if (col_reg == COLS_M1) begin
            state_next = NEWLINE;
          end else begin
            col_next   = col_reg + 6'd1;
            state_next = IDLE;
            ready_next = 1'b1;
          end
        end

        NEWLINE: begin
          col_next = 6'd0;
          if (row_reg < ROWS_M1) begin
            row_next   = row_reg + 5'd1;
            state_next = IDLE;
            ready_next = 1'b1;
          end else begin
            // After scrolling, the new bottom line lives at the old top physical row.
            top_next   = (top_reg == ROWS_M1) ? 5'd0 : top_reg + 5'd1;
            state_next = CLR_LINE;
            we_next    = 1'b1;
            addr_next  = {top_reg, 6'd0};
            din_next   = BLANK;
            cnt_next   = 12'd1;
          end
        end

        CLR_LINE: begin
          if (cnt_reg == CNT_COLS) begin
            state_next = IDLE;
            ready_next = 1'b1;
          end else begin
            we_next   = 1'b1;
            addr_next = {phys_row, cnt_reg[5:0]};
            din_next  = BLANK;
            cnt_next  = cnt_reg + 12'd1;
          end
        end

        default: begin
          state_next = CLR_ALL;
          cnt_next   = 12'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= CLR_ALL;
      cnt_reg   <= 12'd0;
      col_reg   <= 6'd0;
      row_reg   <= 5'd0;
      top_reg   <= 5'd0;
      we_reg    <= 1'b0;
      addr_reg  <= 11'd0;
      din_reg   <= BLANK;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      col_reg   <= col_next;
      row_reg   <= row_next;
      top_reg   <= top_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      din_reg   <= din_next;
      ready_reg <= ready_next;
    end
  end

  assign bus.char_ready = ready_reg;
  assign bus.vram_we    = we_reg;
  assign bus.vram_waddr = addr_reg;
  assign bus.vram_din   = din_reg;
  assign bus.cursor_col = col_reg;
  assign bus.cursor_row = row_reg;
  assign bus.top_row    = top_reg;

endmodule

// File: tb/tb_vram_writer.sv
// Directed bench for vram_writer: full clears, glyph mapping, wrap, scroll, drops, clear abort, reset.
module tb_vram_writer;
  localparam int         COLS  = 40;
  localparam int         ROWS  = 24;
  localparam logic [5:0] BLANK = 6'h20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  vram_writer_if bus ();

  vram_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int rise_cyc = 0;
  logic ready_prev = 1'b0;

  logic [10:0] wr_addr_q[$];
  logic [5:0]  wr_din_q[$];
  int          wr_cyc_q[$];
  int          acc_cyc_q[$];

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (bus.vram_we === 1'b1) begin
      wr_addr_q.push_back(bus.vram_waddr);
      wr_din_q.push_back(bus.vram_din);
      wr_cyc_q.push_back(cycle);
    end
    if (bus.char_ready === 1'b1 && ready_prev !== 1'b1) rise_cyc <= cycle;
    ready_prev <= bus.char_ready;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_din_q.delete();
    wr_cyc_q.delete();
    acc_cyc_q.delete();
  endtask

  task automatic wait_ready(input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < max_cycles; n++) begin
      @(negedge clk);
      #1;
      if (bus.char_ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_eq("ready_timeout", 32'd0, 32'd1);
  endtask

  // Holds char_valid until the writer is ready; the accept happens at the next rising edge.
  task automatic send_char(input logic [6:0] c);
    int n;
    n = 0;
    bus.char_in    = c;
    bus.char_valid = 1'b1;
    while (bus.char_ready !== 1'b1 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 5000) check_eq("send_timeout", 32'd0, 32'd1);
    acc_cyc_q.push_back(cycle);
    @(posedge clk);
    #1;
    bus.char_valid = 1'b0;
    $display("send char %02h accepted in cycle %0d", c, acc_cyc_q[$]);
  endtask

  // Checks a complete 0..2047 BLANK sweep in the write log.
  task automatic check_full_clear(input string tag);
    int bad;
    bad = 0;
    check_eq({tag, "_count"}, wr_addr_q.size(), 32'd2048);
    foreach (wr_addr_q[i]) begin
      if (wr_addr_q[i] !== i[10:0] || wr_din_q[i] !== BLANK) bad++;
    end
    check_eq({tag, "_pattern_errors"}, bad, 32'd0);
    if (wr_addr_q.size() > 0) check_eq({tag, "_first_addr"}, wr_addr_q[0], 32'd0);
    $display("%s: %0d writes observed", tag, wr_addr_q.size());
  endtask

  initial begin
    bus.char_in    = 7'h00;
    bus.char_valid = 1'b0;
    bus.clr_screen = 1'b0;

    // Reset values
    #12;
    check_eq("rst_we", bus.vram_we, 32'd0);
    check_eq("rst_waddr", bus.vram_waddr, 32'd0);
    check_eq("rst_din", bus.vram_din, 32'(BLANK));
    check_eq("rst_ready", bus.char_ready, 32'd0);
    check_eq("rst_cursor", {bus.cursor_row, bus.cursor_col}, 32'd0);
    check_eq("rst_top", bus.top_row, 32'd0);

    // 1: power-up clear
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_log();
    wait_ready(3000);
    check_full_clear("init_clear");
    if (wr_cyc_q.size() > 0) check_eq("init_ready_rise", rise_cyc, wr_cyc_q[$] + 1);
    check_eq("init_cursor", {bus.cursor_row, bus.cursor_col}, 32'd0);

    // 2: 'A' and 'a' map to the same glyph, we one cycle after accept
    clear_log();
    send_char(7'h41);
    send_char(7'h61);
    wait_ready(20);
    check_eq("aa_count", wr_addr_q.size(), 32'd2);
    if (wr_addr_q.size() == 2) begin
      check_eq("A_addr", wr_addr_q[0], 32'd0);
      check_eq("A_din", wr_din_q[0], 32'h01);
      check_eq("a_addr", wr_addr_q[1], 32'd1);
      check_eq("a_din", wr_din_q[1], 32'h01);
      check_eq("A_latency", wr_cyc_q[0], acc_cyc_q[0] + 1);
      check_eq("a_latency", wr_cyc_q[1], acc_cyc_q[1] + 1);
    end
    check_eq("aa_col", bus.cursor_col, 32'd2);

    // clr_screen from IDLE homes the cursor
    @(posedge clk);
    #1 bus.clr_screen = 1'b1;
    @(posedge clk);
    #1 bus.clr_screen = 1'b0;
    clear_log();
    wait_ready(3000);
    check_full_clear("idle_clear");
    check_eq("idle_clear_cursor", {bus.cursor_row, bus.cursor_col}, 32'd0);

    // 3: 41 x '0' wraps onto row 1
    clear_log();
    for (int i = 0; i < 41; i++) send_char(7'h30);
    wait_ready(20);
    check_eq("wrap_count", wr_addr_q.size(), 32'd41);
    if (wr_addr_q.size() == 41) begin
      check_eq("wrap_addr39", wr_addr_q[39], 32'd39);
      check_eq("wrap_addr40", wr_addr_q[40], 32'd64);
      check_eq("wrap_din40", wr_din_q[40], 32'h30);
    end
    check_eq("wrap_row", bus.cursor_row, 32'd1);
    check_eq("wrap_col", bus.cursor_col, 32'd1);

    // 5: control codes dropped; held char waits for ready
    clear_log();
    send_char(7'h07);
    send_char(7'h0A);
    repeat (4) @(posedge clk);
    #1;
    check_eq("ctrl_writes", wr_addr_q.size(), 32'd0);
    check_eq("ctrl_cursor", {bus.cursor_row, bus.cursor_col}, {21'd0, 5'd1, 6'd1});
    clear_log();
    send_char(7'h42);
    send_char(7'h43);
    wait_ready(20);
    check_eq("hold_count", wr_addr_q.size(), 32'd2);
    if (wr_addr_q.size() == 2) begin
      check_eq("hold_B_addr", wr_addr_q[0], 32'd65);
      check_eq("hold_B_din", wr_din_q[0], 32'h02);
      check_eq("hold_C_addr", wr_addr_q[1], 32'd66);
      check_eq("hold_C_din", wr_din_q[1], 32'h03);
      check_eq("hold_gap", acc_cyc_q[1] - acc_cyc_q[0], 32'd2);
    end

    // Move to bottom row with 22 CRs
    clear_log();
    for (int i = 0; i < 22; i++) send_char(7'h0D);
    wait_ready(20);
    check_eq("cr_writes", wr_addr_q.size(), 32'd0);
    check_eq("cr_cursor", {bus.cursor_row, bus.cursor_col}, {21'd0, 5'd23, 6'd0});

    // 4: 24 scrolls, each clearing the old top physical row
    for (int k = 1; k <= 24; k++) begin
      clear_log();
      send_char(7'h0D);
      wait_ready(100);
      check_eq($sformatf("scroll%0d_top", k), bus.top_row, k % ROWS);
      check_eq($sformatf("scroll%0d_count", k), wr_addr_q.size(), 32'd40);
      if (wr_addr_q.size() == 40) begin
        check_eq($sformatf("scroll%0d_first", k), wr_addr_q[0], (k - 1) * 64);
        check_eq($sformatf("scroll%0d_last", k), wr_addr_q[39], (k - 1) * 64 + 39);
        check_eq($sformatf("scroll%0d_din", k), wr_din_q[20], 32'(BLANK));
      end
      check_eq($sformatf("scroll%0d_cursor", k), {bus.cursor_row, bus.cursor_col},
               {21'd0, 5'd23, 6'd0});
    end

    // 6: clr_screen with char_valid during CLR_LINE aborts and restarts a full clear
    send_char(7'h0D);
    repeat (10) @(posedge clk);
    #1;
    check_eq("abort_ready_low", bus.char_ready, 32'd0);
    bus.clr_screen = 1'b1;
    bus.char_valid = 1'b1;
    bus.char_in    = 7'h5A;
    @(posedge clk);
    #1;
    bus.clr_screen = 1'b0;
    bus.char_valid = 1'b0;
    clear_log();
    wait_ready(3000);
    check_full_clear("abort_clear");
    check_eq("abort_top", bus.top_row, 32'd0);
    check_eq("abort_cursor", {bus.cursor_row, bus.cursor_col}, 32'd0);

    // Asynchronous reset in the middle of a clear
    send_char(7'h51);
    wait_ready(20);
    check_eq("pre_rst_col", bus.cursor_col, 32'd1);
    bus.clr_screen = 1'b1;
    @(posedge clk);
    #1 bus.clr_screen = 1'b0;
    repeat (100) @(posedge clk);
    #3;
    check_eq("pre_rst_we", bus.vram_we, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_we", bus.vram_we, 32'd0);
    check_eq("async_rst_waddr", bus.vram_waddr, 32'd0);
    check_eq("async_rst_din", bus.vram_din, 32'(BLANK));
    check_eq("async_rst_ready", bus.char_ready, 32'd0);
    check_eq("async_rst_col", bus.cursor_col, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_log();
    wait_ready(3000);
    check_full_clear("post_rst_clear");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "global timeout");
  end
endmodule
